// File: rtl/barrel_shift_scheduler.sv
// Round-robin two-requester scheduler wrapped around one shared 2**N-bit rotator.
// Optional per-requester grant counters are enabled with the BSS_STATS_EN macro.
module barrel_shift_scheduler #(
  parameter int N = 3,
  localparam int W = 2**N
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_data,
  input  logic [N-1:0] req0_amt,
  input  logic         req0_dir,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_data,
  input  logic [N-1:0] req1_amt,
  input  logic         req1_dir,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id
`ifdef BSS_STATS_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic           lp_r;
  logic           grant_s;
  logic           take_s;
  logic [W-1:0]   opd_data_r;
  logic [N-1:0]   opd_amt_r;
  logic           opd_dir_r;
  logic           opd_id_r;
  logic [2*W-1:0] dbl_s;
  logic [2*W-1:0] shr_s;
  logic [2*W-1:0] shl_s;
  logic [W-1:0]   y_s;

  // Shared rotator: the doubled word turns a plain shift into a rotate.
  always_comb begin
    dbl_s = {opd_data_r, opd_data_r};
    shr_s = dbl_s >> opd_amt_r;
    shl_s = dbl_s << opd_amt_r;
    if (opd_dir_r) begin
      y_s = shl_s[2*W-1:W];
    end else begin
      y_s = shr_s[W-1:0];
    end
  end

  // Next-state, round-robin grant and combinational readies.
  always_comb begin
    state_s    = state_r;
    grant_s    = 1'b0;
    take_s     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          take_s = 1'b1;
          if (req0_valid && req1_valid) begin
            grant_s = ~lp_r;
          end else if (req0_valid) begin
            grant_s = 1'b0;
          end else begin
            grant_s = 1'b1;
          end
          req0_ready = ~grant_s;
          req1_ready = grant_s;
          state_s    = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, last-grant pointer and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lp_r       <= 1'b1;
      opd_data_r <= {W{1'b0}};
      opd_amt_r  <= {N{1'b0}};
      opd_dir_r  <= 1'b0;
      opd_id_r   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= {W{1'b0}};
      rsp_id     <= 1'b0;
    end else begin
      if (take_s) begin
        lp_r       <= grant_s;
        opd_id_r   <= grant_s;
        opd_data_r <= grant_s ? req1_data : req0_data;
        opd_amt_r  <= grant_s ? req1_amt  : req0_amt;
        opd_dir_r  <= grant_s ? req1_dir  : req0_dir;
      end
      if (state_r == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_data  <= y_s;
        rsp_id    <= opd_id_r;
      end else if ((state_r == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef BSS_STATS_EN
  // Saturating accepted-job counters per requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0 <= 16'h0000;
      grant_cnt1 <= 16'h0000;
    end else if (take_s) begin
      if (!grant_s) begin
        if (grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      end else begin
        if (grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_barrel_shift_scheduler.sv
// Self-checking bench for barrel_shift_scheduler: vector table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_barrel_shift_scheduler;
  localparam int N = 3;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic req0_valid, req0_ready, req0_dir;
  logic [W-1:0] req0_data;
  logic [N-1:0] req0_amt;
  logic req1_valid, req1_ready, req1_dir;
  logic [W-1:0] req1_data;
  logic [N-1:0] req1_amt;
  logic rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;
`ifdef BSS_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int bad = 0;
  int cnt0_m = 0;
  int cnt1_m = 0;

  always #5 clk = ~clk;

  barrel_shift_scheduler #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef BSS_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  typedef struct {
    bit         id;
    logic [7:0] d;
    logic [2:0] a;
    bit         dir;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Bit-index definition of a rotate: left moves bit i to i+a, right moves bit i+a to i.
  function automatic logic [7:0] rot_ref(input logic [7:0] d, input int a, input bit left);
    logic [7:0] r;
    for (int i = 0; i < W; i++) begin
      if (left) r[i] = d[(i - a + W) % W];
      else      r[i] = d[(i + a) % W];
    end
    return r;
  endfunction

  task automatic set_req(input bit id, input bit v, input logic [7:0] d, input logic [2:0] a,
                         input bit dir);
    if (id == 1'b0) begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_dir = dir;
    end else begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_dir = dir;
    end
  endtask

  task automatic do_job(input bit id, input logic [7:0] d, input logic [2:0] a, input bit dir,
                        input string nm, input logic [7:0] exp);
    int n;
    bit got;
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(id, 1'b1, d, a, dir);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      #1;
      if (id ? req1_ready : req0_ready) got = 1'b1;
      else begin n++; @(negedge clk); end
    end
    chk({nm, "_accept"}, got, 1);
    if (got) begin
      if (id) cnt1_m++; else cnt0_m++;
    end
    @(negedge clk);
    set_req(id, 1'b0, 8'h00, 3'd0, 1'b0);
    n = 1; got = 1'b0;
    while (!got && n < 20) begin
      #1;
      if (rsp_valid) got = 1'b1;
      else begin n++; @(negedge clk); end
    end
    chk({nm, "_latency"}, n, 2);
    chk({nm, "_data"}, rsp_data, exp);
    chk({nm, "_id"}, rsp_id, id);
    @(negedge clk);
  endtask

  initial begin
    int n, g, rc;
    bit got;
    bit order[4];
    bit busy, exp_id, lp_m, v0, v1, win, r0e, r1e, erv;
    int age;
    logic [7:0] exp_d, hold_d;
    logic [7:0] d0, d1;
    logic [2:0] a0, a1;
    bit dr0, dr1;

    tbl[0] = '{1'b0, 8'hF0, 3'd1, 1'b0, 8'h78};
    tbl[1] = '{1'b1, 8'hF0, 3'd1, 1'b1, 8'hE1};
    tbl[2] = '{1'b0, 8'hF0, 3'd4, 1'b0, 8'h0F};
    tbl[3] = '{1'b1, 8'hF0, 3'd4, 1'b1, 8'h0F};
    tbl[4] = '{1'b0, 8'hF0, 3'd0, 1'b1, 8'hF0};
    tbl[5] = '{1'b1, 8'h81, 3'd7, 1'b1, 8'hC0};
    tbl[6] = '{1'b0, 8'h01, 3'd3, 1'b1, 8'h08};
    tbl[7] = '{1'b1, 8'h81, 3'd1, 1'b0, 8'hC0};

    reset_n = 1'b0; rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_readies", {req0_ready, req1_ready}, 0);

    for (int i = 0; i < 8; i++)
      do_job(tbl[i].id, tbl[i].d, tbl[i].a, tbl[i].dir, $sformatf("vec%0d", i), tbl[i].exp);

    // Back-pressure: result must hold while a new job waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 8'h3C, 3'd2, 1'b0);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      #1;
      if (req0_ready) got = 1'b1;
      else begin n++; @(negedge clk); end
    end
    chk("stall_accept", got, 1);
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'hA5, 3'd3, 1'b1);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      #1;
      if (rsp_valid) got = 1'b1;
      else begin n++; @(negedge clk); end
    end
    chk("stall_data", rsp_data, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall_hold_valid", rsp_valid, 1);
      chk("stall_hold_data", rsp_data, 8'h0F);
      chk("stall_readies", {req0_ready, req1_ready}, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("stall_next_accept", req0_ready, 1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    n = 1; got = 1'b0;
    while (!got && n < 20) begin
      #1;
      if (rsp_valid) got = 1'b1;
      else begin n++; @(negedge clk); end
    end
    chk("stall2_latency", n, 2);
    chk("stall2_data", rsp_data, 8'h2D);
    @(negedge clk);

    // Reset during EXEC discards the job.
    set_req(1'b1, 1'b1, 8'h55, 3'd1, 1'b1);
    #1;
    chk("rexec_accept", req1_ready, 1);
    @(negedge clk);
    set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk("rexec_valid", rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rexec_no_rsp", rsp_valid, 0);
    end

    // Reset during RESP clears the pending result immediately.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 8'h0F, 3'd2, 1'b1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk); #1;
    chk("rresp_pre_valid", rsp_valid, 1);
    chk("rresp_pre_data", rsp_data, 8'h3C);
    reset_n = 1'b0;
    #1;
    chk("rresp_valid", rsp_valid, 0);
    chk("rresp_data", rsp_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt0_m = 0; cnt1_m = 0;

    // Tie after reset: grants alternate starting with requester 0.
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 8'h11, 3'd1, 1'b0);
    set_req(1'b1, 1'b1, 8'h22, 3'd1, 1'b1);
    g = 0; rc = 0; n = 0;
    while (rc < 4 && n < 40) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("tie_one_ready", req0_ready & req1_ready, 0);
        if (g < 4) order[g] = req1_ready;
        if (req1_ready) cnt1_m++; else cnt0_m++;
        g++;
      end
      if (rsp_valid && rsp_ready) begin
        if (rc < g) chk($sformatf("tie_rsp_id%0d", rc), rsp_id, order[rc]);
        rc++;
      end
      n++;
      @(negedge clk);
    end
    chk("tie_rsp_count", rc, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), order[i], i % 2);
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);

    // Randomized traffic against a job-level model.
    busy = 1'b0; age = 0; lp_m = 1'b1; exp_d = 8'h00; exp_id = 1'b0; hold_d = 8'h00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      v0 = ($urandom_range(1, 0) == 1); v1 = ($urandom_range(1, 0) == 1);
      d0 = 8'($urandom); d1 = 8'($urandom);
      a0 = 3'($urandom); a1 = 3'($urandom);
      dr0 = 1'($urandom); dr1 = 1'($urandom);
      set_req(1'b0, v0, d0, a0, dr0);
      set_req(1'b1, v1, d1, a1, dr1);
      rsp_ready = ($urandom_range(9, 0) < 7);
      #1;
      erv = busy && (age >= 1);
      win = (v0 && v1) ? ~lp_m : ~v0;
      r0e = !busy && (v0 || v1) && !win;
      r1e = !busy && (v0 || v1) && win;
      chk("rnd_ready0", req0_ready, r0e);
      chk("rnd_ready1", req1_ready, r1e);
      chk("rnd_rsp_valid", rsp_valid, erv);
      if (erv) begin
        chk("rnd_rsp_data", rsp_data, exp_d);
        chk("rnd_rsp_id", rsp_id, exp_id);
      end
      if (busy) begin
        age++;
        if (erv && rsp_ready) busy = 1'b0;
      end else if (v0 || v1) begin
        busy = 1'b1; age = 0; lp_m = win; exp_id = win;
        exp_d = win ? rot_ref(d1, int'(a1), dr1) : rot_ref(d0, int'(a0), dr0);
        if (win) cnt1_m++; else cnt0_m++;
      end
      hold_d = rsp_data;
    end
    set_req(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);

`ifdef BSS_STATS_EN
    chk("stats_cnt0", grant_cnt0, cnt0_m);
    chk("stats_cnt1", grant_cnt1, cnt1_m);
    force dut.grant_cnt0 = 16'hFFFF;
    @(negedge clk);
    release dut.grant_cnt0;
    do_job(1'b0, 8'hF0, 3'd1, 1'b0, "sat_job", 8'h78);
    chk("stats_sat0", grant_cnt0, 16'hFFFF);
    chk("stats_cnt1_after", grant_cnt1, cnt1_m);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
